// File: rtl/r_empty.sv
// Read-side empty/almost-empty logic for an async FIFO: w_ptr synchronizer, read pointer, flags.
// Optional occupancy output r_level is built when macro R_EMPTY_LEVEL_EN is defined.
module r_empty #(
  parameter int unsigned ADDR_SIZE           = 3,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE:0]   w_ptr,
  input  logic                 r_en,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic [ADDR_SIZE:0]   r_ptr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 underflow
`ifdef R_EMPTY_LEVEL_EN
  ,output logic [ADDR_SIZE:0]  r_level
`endif
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    for (int i = 0; i < int'(PW); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [PW-1:0] wq1_q, wq2_q;
  logic [PW-1:0] r_bin_q, r_bin_d;
  logic [PW-1:0] r_ptr_q, r_ptr_d;
  logic [PW-1:0] occ_d;
  logic          empty_q, empty_d;
  logic          almost_empty_q, almost_empty_d;
  logic          underflow_q, underflow_d;
  logic          rd_ok;

  // Next-state pointer and flag computation from the post-read pointer and synced w_ptr
  always_comb begin
    rd_ok          = r_en & ~empty_q;
    r_bin_d        = r_bin_q + PW'(rd_ok);
    r_ptr_d        = r_bin_d ^ (r_bin_d >> 1);
    empty_d        = (r_ptr_d == wq2_q);
    occ_d          = gray2bin(wq2_q) - r_bin_d;
    almost_empty_d = empty_d | (occ_d <= PW'(ALMOST_EMPTY_THRESH));
    underflow_d    = underflow_q | (r_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wq1_q          <= '0;
      wq2_q          <= '0;
      r_bin_q        <= '0;
      r_ptr_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      wq1_q          <= w_ptr;
      wq2_q          <= wq1_q;
      r_bin_q        <= r_bin_d;
      r_ptr_q        <= r_ptr_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

`ifdef R_EMPTY_LEVEL_EN
  logic [PW-1:0] level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= occ_d;
    end
  end

  assign r_level = level_q;
`endif

  assign r_addr       = r_bin_q[ADDR_SIZE-1:0];
  assign r_ptr        = r_ptr_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_r_empty.sv
// Directed self-checking bench for r_empty (ADDR_SIZE=3, ALMOST_EMPTY_THRESH=2).
module tb_r_empty;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] w_ptr;
  logic       r_en;
  logic [2:0] r_addr;
  logic [3:0] r_ptr;
  logic       empty;
  logic       almost_empty;
  logic       underflow;
`ifdef R_EMPTY_LEVEL_EN
  logic [3:0] r_level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  r_empty #(.ADDR_SIZE(3), .ALMOST_EMPTY_THRESH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .w_ptr        (w_ptr),
    .r_en         (r_en),
    .r_addr       (r_addr),
    .r_ptr        (r_ptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .underflow    (underflow)
`ifdef R_EMPTY_LEVEL_EN
    ,.r_level     (r_level)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    r_en  = 1'b0;
    w_ptr = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] exp_gray [8];
  logic [3:0] saved_ptr;

  initial begin
    exp_gray[0] = 4'b0001; exp_gray[1] = 4'b0011; exp_gray[2] = 4'b0010; exp_gray[3] = 4'b0110;
    exp_gray[4] = 4'b0111; exp_gray[5] = 4'b0101; exp_gray[6] = 4'b0100; exp_gray[7] = 4'b1100;

    // Reset state
    do_reset();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_rptr", 32'(r_ptr), 32'd0);
    check("rst_raddr", 32'(r_addr), 32'd0);
    check("rst_uflow", 32'(underflow), 32'd0);
`ifdef R_EMPTY_LEVEL_EN
    check("rst_level", 32'(r_level), 32'd0);
`endif

    // Synchronizer latency: empty drops only after the third edge
    w_ptr = 4'b0001;
    tick(); check("lat_e1", 32'(empty), 32'd1);
    tick(); check("lat_e2", 32'(empty), 32'd1);
    tick(); check("lat_e3", 32'(empty), 32'd0);
    check("lat_aempty", 32'(almost_empty), 32'd1);
    r_en = 1'b1; tick(); r_en = 1'b0;
    check("lat_raddr", 32'(r_addr), 32'd1);
    check("lat_rptr", 32'(r_ptr), 32'b0001);
    check("lat_empty", 32'(empty), 32'd1);

    // Full FIFO drained with 8 reads, pointer wraps
    do_reset();
    w_ptr = 4'b1100;
    repeat (3) tick();
    check("wrap_empty0", 32'(empty), 32'd0);
    check("wrap_aempty0", 32'(almost_empty), 32'd0);
    r_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("wrap_rptr%0d", k + 1), 32'(r_ptr), 32'(exp_gray[k]));
      check($sformatf("wrap_raddr%0d", k + 1), 32'(r_addr), 32'((k + 1) % 8));
      check($sformatf("wrap_aempty%0d", k + 1), 32'(almost_empty), (k >= 5) ? 32'd1 : 32'd0);
      check($sformatf("wrap_empty%0d", k + 1), 32'(empty), (k == 7) ? 32'd1 : 32'd0);
    end

    // Read while empty: pointer holds, underflow is sticky until reset
    saved_ptr = r_ptr;
    tick(); r_en = 1'b0;
    check("uf_rptr", 32'(r_ptr), 32'b1100);
    check("uf_set", 32'(underflow), 32'd1);
    repeat (10) tick();
    check("uf_sticky", 32'(underflow), 32'd1);
    check("uf_rptr_hold", 32'(r_ptr), 32'(saved_ptr));
    do_reset();
    check("uf_clear", 32'(underflow), 32'd0);

    // Reset overrides a read mid-traversal
    w_ptr = 4'b1100;
    repeat (3) tick();
    r_en = 1'b1;
    repeat (5) tick();
    check("mid_raddr5", 32'(r_addr), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0; r_en = 1'b0;
    check("mid_rptr", 32'(r_ptr), 32'd0);
    check("mid_raddr", 32'(r_addr), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_uflow", 32'(underflow), 32'd0);

    // Occupancy 3 then 2 around the almost-empty threshold
    do_reset();
    w_ptr = 4'b0111;
    repeat (3) tick();
    r_en = 1'b1;
    repeat (2) tick();
    r_en = 1'b0;
    check("lvl_raddr2", 32'(r_addr), 32'd2);
    check("lvl_aempty3", 32'(almost_empty), 32'd0);
`ifdef R_EMPTY_LEVEL_EN
    check("lvl_level3", 32'(r_level), 32'd3);
`endif
    r_en = 1'b1; tick(); r_en = 1'b0;
    check("lvl_aempty2", 32'(almost_empty), 32'd1);
    check("lvl_empty2", 32'(empty), 32'd0);
`ifdef R_EMPTY_LEVEL_EN
    check("lvl_level2", 32'(r_level), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule
